// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : score_keeper
// Description : Pong score keeper. Counts left/right points from wall hits,
//               runs the PLAY / POINT / OVER game state machine, asks for a
//               ball re-centre after each point and renders both scores as
//               seven-segment digits into a registered pixel_valid.
//
// Ports       : clk          system clock, all state on rising edge
//               rst          asynchronous active-low reset
//               hcount       current pixel column
//               vcount       current pixel row
//               vblank       vertical blanking level (frame tick source)
//               coll_wall    ball touching left/right wall (level)
//               ball_dir     1 = ball moving right, 0 = moving left
//               serve        debounced serve button (level)
//               score_left   left score, 0..WIN_SCORE
//               score_right  right score, 0..WIN_SCORE
//               freeze       ball/paddles must hold position
//               ball_reset   one-cycle re-centre request
//               game_over    high in OVER
//               winner       1 = right won, 0 = left won (valid in OVER)
//               pixel_valid  pixel lies on a lit score segment (1-cycle lat.)
//
// Options     : `define SCORE_BLINK_EN to blink the winning digit in OVER
//               (toggles every 16 frames).
//
// Revision    : 1.0 - initial release
// ============================================================================
module score_keeper #(
    parameter int unsigned WIN_SCORE     = 9,
    parameter int unsigned HOLD_FRAMES   = 60,
    parameter logic [10:0] LEFT_DIGIT_H  = 11'd256,
    parameter logic [10:0] RIGHT_DIGIT_H = 11'd368,
    parameter logic [10:0] DIGIT_V       = 11'd32,
    parameter logic [10:0] DIGIT_W       = 11'd32,
    parameter logic [10:0] DIGIT_H       = 11'd56,
    parameter logic [10:0] SEG_T         = 11'd6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        vblank,
    input  logic        coll_wall,
    input  logic        ball_dir,
    input  logic        serve,
    output logic [3:0]  score_left,
    output logic [3:0]  score_right,
    output logic        freeze,
    output logic        ball_reset,
    output logic        game_over,
    output logic        winner,
    output logic        pixel_valid
);

    localparam logic [3:0]  c_win_score = WIN_SCORE[3:0];
    localparam logic [7:0]  c_hold      = HOLD_FRAMES[7:0];
    localparam logic [10:0] c_half_h    = DIGIT_H >> 1;
    localparam logic [10:0] c_half_t    = SEG_T >> 1;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_POINT = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_coll_prev;
    logic        r_serve_prev;
    logic        r_vblank_prev;
    logic [7:0]  r_hold_cnt;
    logic [7:0]  w_hold_nxt;
    logic [3:0]  r_score_l;
    logic [3:0]  r_score_r;
    logic [3:0]  w_score_l_nxt;
    logic [3:0]  w_score_r_nxt;
    logic        r_ball_reset;
    logic        w_ball_reset_nxt;
    logic        r_winner;
    logic        w_winner_nxt;
    logic        r_pix;

    logic        w_coll_rise;
    logic        w_serve_rise;
    logic        w_vblank_rise;
    logic [3:0]  w_score_l_inc;
    logic [3:0]  w_score_r_inc;
    logic [3:0]  w_scorer_new;
    logic        w_lit_l;
    logic        w_lit_r;
    logic        w_hide_l;
    logic        w_hide_r;

    // ------------------------------------------------------------------
    // Edge detection: only the first cycle of a level counts.
    // ------------------------------------------------------------------
    assign w_coll_rise   = coll_wall & ~r_coll_prev;
    assign w_serve_rise  = serve     & ~r_serve_prev;
    assign w_vblank_rise = vblank    & ~r_vblank_prev;

    // Saturating increment: a score can never pass WIN_SCORE.
    assign w_score_l_inc = (r_score_l >= c_win_score) ? r_score_l : r_score_l + 4'd1;
    assign w_score_r_inc = (r_score_r >= c_win_score) ? r_score_r : r_score_r + 4'd1;
    // Ball moving right when it hits a wall means the right wall: left scores.
    assign w_scorer_new  = ball_dir ? w_score_l_inc : w_score_r_inc;

    // ------------------------------------------------------------------
    // State register and game counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_PLAY;
            r_coll_prev   <= 1'b0;
            r_serve_prev  <= 1'b0;
            r_vblank_prev <= 1'b0;
            r_hold_cnt    <= 8'd0;
            r_score_l     <= 4'd0;
            r_score_r     <= 4'd0;
            r_ball_reset  <= 1'b0;
            r_winner      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_coll_prev   <= coll_wall;
            r_serve_prev  <= serve;
            r_vblank_prev <= vblank;
            r_hold_cnt    <= w_hold_nxt;
            r_score_l     <= w_score_l_nxt;
            r_score_r     <= w_score_r_nxt;
            r_ball_reset  <= w_ball_reset_nxt;
            r_winner      <= w_winner_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. ball_reset is registered so it is high during the
    // first cycle spent in POINT, i.e. the cycle the state changes.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_hold_nxt       = r_hold_cnt;
        w_score_l_nxt    = r_score_l;
        w_score_r_nxt    = r_score_r;
        w_ball_reset_nxt = 1'b0;
        w_winner_nxt     = r_winner;
        case (r_state)
            ST_PLAY: begin
                if (w_coll_rise) begin
                    if (ball_dir) begin
                        w_score_l_nxt = w_score_l_inc;
                    end else begin
                        w_score_r_nxt = w_score_r_inc;
                    end
                    if (w_scorer_new == c_win_score) begin
                        w_state_nxt  = ST_OVER;
                        w_winner_nxt = ~ball_dir;
                    end else begin
                        w_state_nxt      = ST_POINT;
                        w_hold_nxt       = c_hold;
                        w_ball_reset_nxt = 1'b1;
                    end
                end
            end
            ST_POINT: begin
                if (w_vblank_rise) begin
                    if (r_hold_cnt <= 8'd1) begin
                        w_hold_nxt  = 8'd0;
                        w_state_nxt = ST_PLAY;
                    end else begin
                        w_hold_nxt = r_hold_cnt - 8'd1;
                    end
                end
            end
            ST_OVER: begin
                if (w_serve_rise) begin
                    w_score_l_nxt    = 4'd0;
                    w_score_r_nxt    = 4'd0;
                    w_ball_reset_nxt = 1'b1;
                    w_state_nxt      = ST_POINT;
                    w_hold_nxt       = c_hold;
                end
            end
            default: begin
                w_state_nxt = ST_PLAY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Seven-segment rendering
    // ------------------------------------------------------------------
    // Segment pattern packed as {a,b,c,d,e,f,g}; out-of-range values blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] val);
        case (val)
            4'd0:    seg_decode = 7'h7E;
            4'd1:    seg_decode = 7'h30;
            4'd2:    seg_decode = 7'h6D;
            4'd3:    seg_decode = 7'h79;
            4'd4:    seg_decode = 7'h33;
            4'd5:    seg_decode = 7'h5B;
            4'd6:    seg_decode = 7'h5F;
            4'd7:    seg_decode = 7'h70;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h7B;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    function automatic logic digit_lit(
        input logic [10:0] hc,
        input logic [10:0] vc,
        input logic [10:0] org,
        input logic [3:0]  val
    );
        logic [10:0] dx;
        logic [10:0] dy;
        logic [10:0] g_dist;
        logic        in_box;
        logic        upper;
        logic [6:0]  segs;
        dx     = hc - org;
        dy     = vc - DIGIT_V;
        // Coordinates left of / above the digit wrap to huge values; the
        // explicit >= tests keep that wrap from ever aliasing into the box.
        in_box = (hc >= org) && (vc >= DIGIT_V) && (dx < DIGIT_W) && (dy < DIGIT_H);
        upper  = (dy < c_half_h);
        g_dist = (dy >= c_half_h) ? (dy - c_half_h) : (c_half_h - dy);
        segs   = seg_decode(val);
        digit_lit = in_box && (
            (segs[6] && (dy < SEG_T))                          ||
            (segs[5] &&  upper && (dx >= DIGIT_W - SEG_T))     ||
            (segs[4] && !upper && (dx >= DIGIT_W - SEG_T))     ||
            (segs[3] && (dy >= DIGIT_H - SEG_T))               ||
            (segs[2] && !upper && (dx < SEG_T))                ||
            (segs[1] &&  upper && (dx < SEG_T))                ||
            (segs[0] && (g_dist < c_half_t)));
    endfunction

    assign w_lit_l = digit_lit(hcount, vcount, LEFT_DIGIT_H,  r_score_l) & ~w_hide_l;
    assign w_lit_r = digit_lit(hcount, vcount, RIGHT_DIGIT_H, r_score_r) & ~w_hide_r;

`ifdef SCORE_BLINK_EN
    logic [4:0] r_blink_cnt;

    // Free-running frame counter; restarted when a new game begins so the
    // next game-over blink always starts in the visible phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt <= 5'd0;
        end else if ((r_state == ST_OVER) && (w_state_nxt != ST_OVER)) begin
            r_blink_cnt <= 5'd0;
        end else if (w_vblank_rise) begin
            r_blink_cnt <= r_blink_cnt + 5'd1;
        end
    end

    assign w_hide_l = (r_state == ST_OVER) && r_blink_cnt[4] && !r_winner;
    assign w_hide_r = (r_state == ST_OVER) && r_blink_cnt[4] &&  r_winner;
`else
    assign w_hide_l = 1'b0;
    assign w_hide_r = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix <= 1'b0;
        end else begin
            r_pix <= ~vblank & (w_lit_l | w_lit_r);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign score_left  = r_score_l;
    assign score_right = r_score_r;
    assign freeze      = (r_state != ST_PLAY);
    assign game_over   = (r_state == ST_OVER);
    assign ball_reset  = r_ball_reset;
    assign winner      = r_winner;
    assign pixel_valid = r_pix;

endmodule
`default_nettype wire

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Downstream consumer of the collision detector's wall-hit output and the ball's horizontal direction.
- Tracks left/right scores and runs the point / game-over state machine.
- Requests ball re-centre after each point.
- Produces a registered pixel_valid that draws both scores as seven-segment digits. The top level ORs it into color with the ball, background and paddle layers.

Parameters:
WIN_SCORE, 9, score at which a game ends (1..9)
HOLD_FRAMES, 60, frames play stays frozen after a point (1..255)
LEFT_DIGIT_H, 11'd256, left digit left-edge hcount
RIGHT_DIGIT_H, 11'd368, right digit left-edge hcount
DIGIT_V, 11'd32, top vcount of both digits
DIGIT_W, 11'd32, digit width in pixels
DIGIT_H, 11'd56, digit height in pixels
SEG_T, 11'd6, segment thickness in pixels

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  reset, asynchronous, active-low
hcount  input  11  current pixel column from the VGA controller
vcount  input  11  current pixel row from the VGA controller
vblank  input  1  vertical blanking, level
coll_wall  input  1  ball at left/right wall, level, may stay high several cycles
ball_dir  input  1  ball horizontal direction: 1 = moving right, 0 = moving left
serve  input  1  raw serve button (already debounced), level
score_left  output  4  left player score, 0..WIN_SCORE
score_right  output  4  right player score, 0..WIN_SCORE
freeze  output  1  high while ball/paddles must hold position
ball_reset  output  1  one-cycle pulse: re-centre ball
game_over  output  1  high in OVER state
winner  output  1  valid when game_over: 1 = right won, 0 = left won
pixel_valid  output  1  current pixel lies on a lit score segment

Behaviour:
- Reset (rst low, async) forces:
  - state PLAY; scores 0; freeze 0; ball_reset 0; game_over 0; winner 0; pixel_valid 0.
  - Edge-detect registers cleared.
- Edge detection: coll_wall, serve and vblank are each registered once; rising edge = cur & ~prev. Level inputs never count twice.
- State PLAY:
  - On coll_wall rise, the scoring side is: ball_dir=1 → left scores; ball_dir=0 → right scores.
  - The scorer's score increments by 1 next cycle.
  - If the new score == WIN_SCORE → OVER, with winner = 1 if right scored, 0 if left scored.
  - Otherwise → POINT; load frame counter with HOLD_FRAMES; pulse ball_reset for exactly 1 cycle (the cycle the state changes).
- State POINT:
  - freeze=1.
  - Counter decrements on each vblank rise.
  - Counter reaching 0 → PLAY, freeze=0 from the following cycle.
  - coll_wall ignored.
- State OVER:
  - freeze=1; game_over=1; scores hold; coll_wall ignored.
  - On serve rise: both scores → 0, ball_reset pulses 1 cycle → POINT with HOLD_FRAMES.
- serve rise outside OVER is ignored.
- coll_wall rise and serve rise in the same cycle: only the one relevant to the current state acts.
- Scores never exceed WIN_SCORE; a 4-bit increment with no wrap.
- Rendering, per digit:
  - Local coords dx = hcount − digit_h and dy = vcount − DIGIT_V, both 11-bit; valid only when hcount ≥ digit_h, dx < DIGIT_W and dy < DIGIT_H.
  - Segment bands: a: dy < SEG_T; g: |dy − DIGIT_H/2| < SEG_T/2; d: dy ≥ DIGIT_H − SEG_T; f/e: dx < SEG_T in the upper/lower half; b/c: dx ≥ DIGIT_W − SEG_T in the upper/lower half.
  - Standard 0–9 segment table; values >9 light nothing.
  - pixel_valid = OR of both digits, registered: 1-cycle latency from hcount/vcount.
  - Forced 0 while vblank=1.

Optional Feature:
SCORE_BLINK_EN
- Defined:
  - A 5-bit frame counter increments on each vblank rise, in all states.
  - In OVER, the winner's digit is suppressed from pixel_valid while counter[4]=1 (blinks every 16 frames).
  - Counter resets to 0 on reset and on leaving OVER.
- Undefined: no counter is built; digits render steadily in all states.

Test Plan:
- Reset mid-POINT (rst low 3 cycles at frame count 30) → all outputs 0, state PLAY, scores 0 one cycle after release.
- ball_dir=1, coll_wall high for 5 cycles → score_left=1 (not 5), score_right=0, ball_reset high exactly 1 cycle, freeze=1.
- In POINT with HOLD_FRAMES=3 → freeze drops after the 3rd vblank rise; coll_wall pulses during the hold leave scores unchanged.
- Right scores 9 times (WIN_SCORE=9) → game_over=1, winner=1, score_right=9; further coll_wall leaves score at 9.
- In OVER, serve rise → scores 0, ball_reset pulse, state POINT; serve rise during PLAY → no change.
- score_left=8 → pixel_valid=1 at (hcount=LEFT_DIGIT_H+16, vcount=DIGIT_V+2), one cycle after the coordinate is presented. With score 1 → 0 at (LEFT_DIGIT_H+2, DIGIT_V+10). Always 0 when vblank=1.
